// File: rtl/nine_segment_pkg.sv
// Shared constants and pin-to-segment mapping for the 3x3 common-anode
// nine-segment interface (driver and receive-side decoder).
package nine_segment_pkg;

   localparam int SEG_W = 9;
   localparam int ROW_N = 3;
   localparam int COL_N = 3;

   // Bit position of the segment lit by (row, col).
   function automatic int unsigned seg_index(input int unsigned row,
                                             input int unsigned col);
      return COL_N * row + col;
   endfunction

endpackage

// File: rtl/nine_segment_frame_filter.sv
// Stability filter: publishes a frame candidate only after it has been seen
// STABLE_FRAMES times in a row, and only when it differs from what is shown.
module nine_segment_frame_filter
   import nine_segment_pkg::*;
#(
   parameter int STABLE_FRAMES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEG_W-1:0] frame_i,
   input  logic             strobe_i,
   output logic [SEG_W-1:0] segments_o,
   output logic             update_o
);

   localparam int MCNT_W = $clog2(STABLE_FRAMES + 1);
   localparam logic [MCNT_W-1:0] MCNT_MAX = MCNT_W'(STABLE_FRAMES);

   logic [SEG_W-1:0]  prev_q, prev_d;
   logic [SEG_W-1:0]  seg_q, seg_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   logic              update_q, update_d;

   // Match counting against the previous frame and publish decision.
   always_comb begin
      prev_d   = prev_q;
      mcnt_d   = mcnt_q;
      seg_d    = seg_q;
      update_d = 1'b0;
      if (strobe_i) begin
         if (frame_i == prev_q) begin
            if (mcnt_q != MCNT_MAX) mcnt_d = mcnt_q + 1'b1;
         end else begin
            prev_d = frame_i;
            mcnt_d = MCNT_W'(1);
         end
         if ((mcnt_d == MCNT_MAX) && (frame_i != seg_q)) begin
            seg_d    = frame_i;
            update_d = 1'b1;
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q   <= '0;
         mcnt_q   <= '0;
         seg_q    <= '0;
         update_q <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         mcnt_q   <= mcnt_d;
         seg_q    <= seg_d;
         update_q <= update_d;
      end
   end

   assign segments_o = seg_q;
   assign update_o   = update_q;

endmodule

// File: rtl/six_pin_to_nine_segment.sv
// Receive-side decoder for the 3x3 row-scanned pin interface: registers the
// pins, ORs each single-row cycle into a frame over a free-running window and
// hands each completed frame to the stability filter.
module six_pin_to_nine_segment
   import nine_segment_pkg::*;
#(
   parameter int FRAME_CYCLES  = 3,
   parameter int STABLE_FRAMES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ROW_N-1:0] rows,
   input  logic [COL_N-1:0] cols,
   output logic [SEG_W-1:0] segments,
   output logic             frame_done,
   output logic             update,
   output logic             conflict
);

   localparam int WCNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_CYCLES - 1);

   logic [ROW_N-1:0]  rows_q;
   logic [COL_N-1:0]  cols_q;
   logic              conflict_q;
   logic              frame_done_q;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [SEG_W-1:0]  acc_q, acc_d;
   logic [SEG_W-1:0]  contrib;
   logic [SEG_W-1:0]  frame_cand;
   logic              one_row;
   logic              win_end;

   // A sampled cycle only counts when exactly one row is driven.
   assign one_row = ($countones(rows_q) == 1);

   for (genvar r = 0; r < ROW_N; r++) begin : g_row
      localparam int unsigned BASE = seg_index(r, 0);
      assign contrib[BASE +: COL_N] = (one_row && rows_q[r]) ? ~cols_q : '0;
   end

   assign win_end    = (wcnt_q == WCNT_LAST);
   assign frame_cand = acc_q | contrib;

   // Window counter wrap and accumulator clear at the window end.
   always_comb begin
      wcnt_d = wcnt_q + 1'b1;
      acc_d  = frame_cand;
      if (win_end) begin
         wcnt_d = '0;
         acc_d  = '0;
      end
   end

   // Pin sampling, conflict detection on raw pins, window state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rows_q       <= '0;
         cols_q       <= '0;
         conflict_q   <= 1'b0;
         frame_done_q <= 1'b0;
         wcnt_q       <= '0;
         acc_q        <= '0;
      end else begin
         rows_q       <= rows;
         cols_q       <= cols;
         conflict_q   <= ($countones(rows) > 1);
         frame_done_q <= win_end;
         wcnt_q       <= wcnt_d;
         acc_q        <= acc_d;
      end
   end

   nine_segment_frame_filter #(
      .STABLE_FRAMES(STABLE_FRAMES)
   ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .frame_i   (frame_cand),
      .strobe_i  (win_end),
      .segments_o(segments),
      .update_o  (update)
   );

   assign frame_done = frame_done_q;
   assign conflict   = conflict_q;

endmodule

// File: tb/tb_six_pin_to_nine_segment.sv
// Randomized and directed bench for six_pin_to_nine_segment with a
// frame-level reference model (pins grouped per window, then filtered).
module tb_six_pin_to_nine_segment;

   localparam int FC = 3;
   localparam int SF = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] rows, cols;
   logic [8:0] segments;
   logic       frame_done, update, conflict;

   six_pin_to_nine_segment #(.FRAME_CYCLES(FC), .STABLE_FRAMES(SF)) dut (
      .clk(clk), .reset(reset), .rows(rows), .cols(cols),
      .segments(segments), .frame_done(frame_done),
      .update(update), .conflict(conflict)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int         ecnt;
   int         mcount;
   logic [8:0] macc, mprev, mseg;
   logic [8:0] exp_seg;
   logic       exp_fd, exp_up, exp_cf;

   logic [2:0] SR [3] = '{3'b100, 3'b010, 3'b001};
   logic [2:0] SC [3] = '{3'b010, 3'b101, 3'b110};
   int         sidx = 0;

   function automatic logic [8:0] decode(input logic [2:0] r, input logic [2:0] c);
      logic [8:0] d;
      d = '0;
      if ($countones(r) == 1)
         for (int i = 0; i < 3; i++)
            if (r[i])
               for (int j = 0; j < 3; j++) d[3*i + j] = ~c[j];
      return d;
   endfunction

   // Drive one cycle, advance past the edge, update the model's expectations.
   // Pins sampled at post-reset edge n belong to the window closing at the
   // next multiple of FC strictly after n.
   task automatic tick(input logic rst, input logic [2:0] r, input logic [2:0] c);
      logic [8:0] f;
      reset = rst; rows = r; cols = c;
      @(posedge clk); #1;
      exp_fd = 1'b0; exp_up = 1'b0; exp_cf = 1'b0;
      if (rst) begin
         ecnt = 0; mcount = 0; macc = '0; mprev = '0; mseg = '0;
      end else begin
         ecnt++;
         exp_cf = ($countones(r) >= 2);
         if (ecnt % FC == 0) begin
            exp_fd = 1'b1;
            f = macc;
            if (f == mprev) mcount = (mcount < SF) ? mcount + 1 : SF;
            else begin mprev = f; mcount = 1; end
            if (mcount == SF && f != mseg) begin mseg = f; exp_up = 1'b1; end
            macc = decode(r, c);
         end else begin
            macc = macc | decode(r, c);
         end
      end
      exp_seg = mseg;
   endtask

   task automatic tick_slot();
      tick(1'b0, SR[sidx], SC[sidx]);
      sidx = (sidx + 1) % 3;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 3'($urandom), 3'($urandom));
         checks++;
         if ({segments, frame_done, update, conflict} !== 12'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b exp 0", {segments, frame_done, update, conflict});
         end
      end
      tick(1'b0, 3'b000, 3'b111);
      checks++;
      if ({segments, frame_done, update, conflict} !== 12'b0) begin
         errors++;
         $display("FAIL reset_first_cycle: got %b exp 0", {segments, frame_done, update, conflict});
      end
   endtask

   task automatic test_decode();
      int nup = 0;
      int nfd = 0;
      sidx = 0;
      for (int i = 0; i < 24; i++) begin
         tick_slot();
         nup += int'(update);
         nfd += int'(frame_done);
         checks++;
         if ({segments, frame_done, update, conflict} !== {exp_seg, exp_fd, exp_up, exp_cf}) begin
            errors++;
            $display("FAIL decode_cycle%0d: got %b exp %b", i,
                     {segments, frame_done, update, conflict}, {exp_seg, exp_fd, exp_up, exp_cf});
         end
      end
      checks++;
      if (segments !== 9'b101_010_001 || nup != 1 || nfd != 8) begin
         errors++;
         $display("FAIL decode_result: got seg %b updates %0d frames %0d exp seg 101010001 updates 1 frames 8",
                  segments, nup, nfd);
      end
   endtask

   task automatic test_empty_row();
      int nup = 0;
      for (int i = 0; i < 24; i++) begin
         if (sidx == 1) begin tick(1'b0, 3'b000, 3'b000); sidx = 2; end
         else tick_slot();
         nup += int'(update);
         checks++;
         if ({segments, frame_done, update, conflict} !== {exp_seg, exp_fd, exp_up, exp_cf}) begin
            errors++;
            $display("FAIL empty_row_cycle%0d: got %b exp %b", i,
                     {segments, frame_done, update, conflict}, {exp_seg, exp_fd, exp_up, exp_cf});
         end
      end
      checks++;
      if (segments !== 9'b101_000_001 || nup != 1) begin
         errors++;
         $display("FAIL empty_row_result: got seg %b updates %0d exp seg 101000001 updates 1", segments, nup);
      end
   endtask

   task automatic test_conflict();
      int ncf = 0;
      int nup = 0;
      for (int i = 0; i < 18; i++) tick_slot();
      checks++;
      if (segments !== 9'b101_010_001) begin
         errors++;
         $display("FAIL conflict_restore: got %b exp 101010001", segments);
      end
      for (int i = 0; i < 18; i++) begin
         if (i == 7) begin tick(1'b0, 3'b110, 3'b000); sidx = (sidx + 1) % 3; end
         else tick_slot();
         ncf += int'(conflict);
         nup += int'(update);
         checks++;
         if ({segments, frame_done, update, conflict} !== {exp_seg, exp_fd, exp_up, exp_cf}) begin
            errors++;
            $display("FAIL conflict_cycle%0d: got %b exp %b", i,
                     {segments, frame_done, update, conflict}, {exp_seg, exp_fd, exp_up, exp_cf});
         end
      end
      checks++;
      if (ncf != 1 || nup != 0 || segments !== 9'b101_010_001) begin
         errors++;
         $display("FAIL conflict_result: got pulses %0d updates %0d seg %b exp 1 0 101010001",
                  ncf, nup, segments);
      end
   endtask

   task automatic test_flicker();
      logic [2:0] fr [3] = '{3'b100, 3'b010, 3'b001};
      logic [2:0] fc [3] = '{3'b000, 3'b111, 3'b000};
      int nup = 0;
      while ((ecnt + 1) % FC != 0) tick_slot();
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, fr[i], fc[i]);
         nup += int'(update);
      end
      for (int i = 0; i < 12; i++) begin
         tick_slot();
         nup += int'(update);
         checks++;
         if (segments !== 9'b101_010_001) begin
            errors++;
            $display("FAIL flicker_seg%0d: got %b exp 101010001", i, segments);
         end
      end
      checks++;
      if (nup != 0) begin
         errors++;
         $display("FAIL flicker_updates: got %0d exp 0", nup);
      end
   endtask

   task automatic test_random();
      logic [2:0] rr [3];
      logic [2:0] rc [3];
      for (int p = 0; p < 40; p++) begin
         for (int s = 0; s < 3; s++) begin
            rr[s] = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) rr[s] = 3'($urandom);
            rc[s] = 3'($urandom);
         end
         for (int k = 0; k < 3 * int'($urandom_range(1, 4)); k++) begin
            tick(1'b0, rr[k % 3], rc[k % 3]);
            checks++;
            if ({segments, frame_done, update, conflict} !== {exp_seg, exp_fd, exp_up, exp_cf}) begin
               errors++;
               $display("FAIL random_p%0d_k%0d: got %b exp %b", p, k,
                        {segments, frame_done, update, conflict}, {exp_seg, exp_fd, exp_up, exp_cf});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int first = 0;
      tick_slot();
      while (ecnt % FC != 1) tick_slot();
      tick(1'b1, SR[sidx], SC[sidx]);
      checks++;
      if ({segments, frame_done, update, conflict} !== 12'b0) begin
         errors++;
         $display("FAIL reset_mid_clear: got %b exp 0", {segments, frame_done, update, conflict});
      end
      for (int k = 1; k <= 10 && first == 0; k++) begin
         tick_slot();
         if (frame_done === 1'b1) first = k;
         checks++;
         if ({segments, frame_done, update, conflict} !== {exp_seg, exp_fd, exp_up, exp_cf}) begin
            errors++;
            $display("FAIL reset_mid_cycle%0d: got %b exp %b", k,
                     {segments, frame_done, update, conflict}, {exp_seg, exp_fd, exp_up, exp_cf});
         end
      end
      checks++;
      if (first != 3) begin
         errors++;
         $display("FAIL reset_mid_frame_done: got cycle %0d exp 3 (0 = none within bound)", first);
      end
      for (int k = 0; k < 9; k++) tick_slot();
      checks++;
      if (segments !== 9'b101_010_001) begin
         errors++;
         $display("FAIL reset_mid_recover: got %b exp 101010001", segments);
      end
   endtask

   initial begin
      reset = 1'b1; rows = '0; cols = '0;
      ecnt = 0; mcount = 0; macc = '0; mprev = '0; mseg = '0;
      exp_seg = '0; exp_fd = 1'b0; exp_up = 1'b0; exp_cf = 1'b0;
      test_reset();
      test_decode();
      test_empty_row();
      test_conflict();
      test_flicker();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
